// File: rtl/regs_pkg.sv
// Shared widths and constants for the RV32I integer register file.
package regs_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_NUM    = 2 ** REG_ADDR_W;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG  = '0;
    localparam logic [XLEN-1:0]       ZERO_WORD = '0;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

endpackage

// File: rtl/regs_rd_port.sv
// One id-stage source-operand read port: x0, then same-cycle bypass, then stored word.
module regs_rd_port
    import regs_pkg::*;
#(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] raddr_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic [XLEN-1:0]       wdata_i,
    input  logic                  wen_i,
    input  logic [XLEN-1:0]       stored_i,
    output logic [XLEN-1:0]       rdata_o
);

    logic hit;

    // Gated on a known-low enable, so an X address cannot leak into the result.
    assign hit = BYPASS_EN && (wen_i == WRITE_ENABLE) && (waddr_i == raddr_i);

    always_comb begin
        rdata_o = ZERO_WORD;
        if (rst_i) begin
            rdata_o = ZERO_WORD;
        end else if (raddr_i == ZERO_REG) begin
            rdata_o = ZERO_WORD;
        end else if (hit) begin
            rdata_o = wdata_i;
        end else begin
            rdata_o = stored_i;
        end
    end

endmodule

// File: rtl/regs.sv
// 32 x 32 integer register file: two bypassed id read ports, one ex write port,
// and a non-bypassed debug read port.
module regs
    import regs_pkg::*;
#(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] reg1_raddr_i,
    input  logic [REG_ADDR_W-1:0] reg2_raddr_i,
    output logic [XLEN-1:0]       reg1_rdata_o,
    output logic [XLEN-1:0]       reg2_rdata_o,
    input  logic [REG_ADDR_W-1:0] reg_waddr_i,
    input  logic [XLEN-1:0]       reg_wdata_i,
    input  logic                  reg_wen_i,
    input  logic [REG_ADDR_W-1:0] dbg_raddr_i,
    output logic [XLEN-1:0]       dbg_rdata_o
);

    logic [XLEN-1:0] mem_q [REG_NUM-1:1];
    logic [XLEN-1:0] mem_d [REG_NUM-1:1];
    logic [XLEN-1:0] rf    [REG_NUM];

    always_comb begin
        for (int i = 1; i < REG_NUM; i++) begin
            mem_d[i] = mem_q[i];
            if (reg_wen_i == WRITE_ENABLE && reg_waddr_i == REG_ADDR_W'(i)) begin
                mem_d[i] = reg_wdata_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 1; i < REG_NUM; i++) begin
            if (rst) begin
                mem_q[i] <= ZERO_WORD;
            end else begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Full 0..31 view with x0 tied to zero, so every address indexes safely.
    always_comb begin
        rf[0] = ZERO_WORD;
        for (int i = 1; i < REG_NUM; i++) begin
            rf[i] = mem_q[i];
        end
    end

    regs_rd_port #(.BYPASS_EN(BYPASS_EN)) u_rd1 (
        .rst_i    (rst),
        .raddr_i  (reg1_raddr_i),
        .waddr_i  (reg_waddr_i),
        .wdata_i  (reg_wdata_i),
        .wen_i    (reg_wen_i),
        .stored_i (rf[reg1_raddr_i]),
        .rdata_o  (reg1_rdata_o)
    );

    regs_rd_port #(.BYPASS_EN(BYPASS_EN)) u_rd2 (
        .rst_i    (rst),
        .raddr_i  (reg2_raddr_i),
        .waddr_i  (reg_waddr_i),
        .wdata_i  (reg_wdata_i),
        .wen_i    (reg_wen_i),
        .stored_i (rf[reg2_raddr_i]),
        .rdata_o  (reg2_rdata_o)
    );

    assign dbg_rdata_o = rst ? ZERO_WORD : rf[dbg_raddr_i];

endmodule

// File: tb/tb_regs.sv
// Register file bench: directed literal cases plus random traffic against a model,
// run on a bypassing and a non-bypassing instance side by side.
module tb_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra1, ra2, wa, da;
    logic [31:0] wd;
    logic        we;
    logic [31:0] r1, r2, dbg;
    logic [31:0] n1, n2, ndbg;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [31:0] model [32];

    always #5 clk = ~clk;

    regs #(.BYPASS_EN(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .reg1_raddr_i (ra1),
        .reg2_raddr_i (ra2),
        .reg1_rdata_o (r1),
        .reg2_rdata_o (r2),
        .reg_waddr_i  (wa),
        .reg_wdata_i  (wd),
        .reg_wen_i    (we),
        .dbg_raddr_i  (da),
        .dbg_rdata_o  (dbg)
    );

    regs #(.BYPASS_EN(1'b0)) dut_nb (
        .clk          (clk),
        .rst          (rst),
        .reg1_raddr_i (ra1),
        .reg2_raddr_i (ra2),
        .reg1_rdata_o (n1),
        .reg2_rdata_o (n2),
        .reg_waddr_i  (wa),
        .reg_wdata_i  (wd),
        .reg_wen_i    (we),
        .dbg_raddr_i  (da),
        .dbg_rdata_o  (ndbg)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural state: reset clears, enabled writes to x1..x31 land.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (we && wa != 5'd0) begin
            model[wa] = wd;
        end
    end

    function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
        if (rst || a == 5'd0) return 32'd0;
        if (byp && we && wa == a) return wd;
        return model[a];
    endfunction

    function automatic logic [31:0] exp_dbg(input logic [4:0] a);
        if (rst || a == 5'd0) return 32'd0;
        return model[a];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_r1",   r1,   exp_rd(1'b1, ra1));
            chk("m_r2",   r2,   exp_rd(1'b1, ra2));
            chk("m_dbg",  dbg,  exp_dbg(da));
            chk("m_nb_r1", n1,  exp_rd(1'b0, ra1));
            chk("m_nb_r2", n2,  exp_rd(1'b0, ra2));
            chk("m_nb_dbg", ndbg, exp_dbg(da));
        end
    end

    task automatic cyc(input logic r, input logic e, input logic [4:0] a,
                       input logic [31:0] d, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] ad);
        @(posedge clk);
        #1;
        rst = r; we = e; wa = a; wd = d;
        ra1 = a1; ra2 = a2; da = ad;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0;
        ra1 = '0; ra2 = '0; da = '0;
        @(posedge clk);
        #1 chk_en = 1'b1;

        cyc(1, 0, 0, 0, 5, 5, 5);
        chk("rst_r1", r1, 32'd0);

        // Reset clears a preloaded register.
        cyc(0, 1, 5, 32'hDEADBEEF, 5, 5, 5);
        chk("pre_byp", r1, 32'hDEADBEEF);
        chk("pre_dbg", dbg, 32'd0);
        cyc(0, 0, 0, 0, 5, 5, 5);
        chk("pre_dbg2", dbg, 32'hDEADBEEF);
        cyc(1, 0, 0, 0, 5, 5, 5);
        chk("rst_hold_r1", r1, 32'd0);
        chk("rst_hold_dbg", dbg, 32'd0);
        cyc(0, 0, 0, 0, 5, 5, 5);
        chk("rst_clr_r1", r1, 32'd0);
        chk("rst_clr_dbg", dbg, 32'd0);

        // Basic write then read.
        cyc(0, 1, 3, 32'h123, 4, 0, 3);
        chk("wr_r1_x4", r1, 32'd0);
        chk("wr_dbg_same", dbg, 32'd0);
        cyc(0, 0, 0, 0, 3, 0, 3);
        chk("wr_r1", r1, 32'h123);
        chk("wr_dbg", dbg, 32'h123);

        // x0 is never written.
        cyc(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0);
        chk("x0_r1", r1, 32'd0);
        chk("x0_r2", r2, 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("x0_r1_n", r1, 32'd0);
        chk("x0_r2_n", r2, 32'd0);
        chk("x0_dbg", dbg, 32'd0);

        // Bypass on both ports; non-bypass instance sees stored value.
        cyc(0, 1, 7, 32'h11, 0, 0, 0);
        cyc(0, 1, 7, 32'h22, 7, 7, 7);
        chk("byp_r1", r1, 32'h22);
        chk("byp_r2", r2, 32'h22);
        chk("byp_dbg", dbg, 32'h11);
        chk("nb_r1", n1, 32'h11);
        chk("nb_r2", n2, 32'h11);
        cyc(0, 0, 0, 0, 7, 7, 7);
        chk("byp_dbg_n", dbg, 32'h22);
        chk("nb_r1_n", n1, 32'h22);

        // Reset beats a same-edge write.
        cyc(1, 1, 9, 32'hA5A5A5A5, 9, 9, 9);
        chk("coll_r1", r1, 32'd0);
        cyc(0, 0, 0, 0, 9, 9, 9);
        chk("coll_r1_n", r1, 32'd0);
        chk("coll_dbg", dbg, 32'd0);

        // Back-to-back fill, a disabled write, then sweep.
        for (int a = 1; a < 32; a++) begin
            cyc(0, 1, 5'(a), 32'(a) * 32'h01010101, 0, 0, 0);
        end
        cyc(0, 0, 2, 0, 2, 2, 2);
        chk("wen0_r1", r1, 32'h02020202);
        for (int a = 1; a < 32; a++) begin
            cyc(0, 0, 5'($urandom_range(31)), $urandom, 5'(a), 5'(32 - a), 5'(a));
            chk("sweep_r1", r1, 32'(a) * 32'h01010101);
            chk("sweep_r2", r2, 32'(32 - a) * 32'h01010101);
            chk("sweep_dbg", dbg, 32'(a) * 32'h01010101);
        end

        // Random traffic, addresses biased towards collisions.
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] pick [3];
            for (int k = 0; k < 3; k++) begin
                pick[k] = ($urandom_range(3) == 0) ? 5'($urandom_range(31))
                                                   : 5'($urandom_range(4));
            end
            cyc(($urandom_range(63) == 0), $urandom_range(1) == 1,
                5'($urandom_range(4)), $urandom, pick[0], pick[1], pick[2]);
        end

        @(posedge clk);
        #1 chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
